ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 108 ++++++++++
 tb/tb_ifu_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC sequencing, imem handshake, held-instruction handoff
// Optional macro IFU_ALIGN_CHECK_EN: a misaligned next-PC halts the unit and sets misalign.
// When the macro is undefined, the low two bits of the next-PC are forced to zero.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  output logic        misalign
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]  state;
  logic [31:0] br_off;
  logic [31:0] npc_raw;
  logic [31:0] npc;

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pc4         = pc + 32'd4;

  // Next-PC selection from the decoder code; only consumed in the retire cycle.
  always_comb begin
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    npc_raw = pc4;
    case (npc_op)
      3'b001:         npc_raw = br_taken ? (pc4 + br_off) : pc4;
      3'b010, 3'b011: npc_raw = {pc[31:28], instr[25:0], 2'b00};
      3'b100:         npc_raw = rs_data;
      default:        npc_raw = pc4;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign npc = npc_raw;

  // Fetch sequencer; a misaligned target freezes pc and parks the unit in HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      instr    <= '0;
      misalign <= 1'b0;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (imem_ack) begin
                 instr <= imem_rdata;
                 state <= HOLD;
               end
        HOLD:  if (instr_ready) begin
                 if (|npc[1:0]) begin
                   misalign <= 1'b1;
                   state    <= HALT;
                 end else begin
                   pc    <= npc;
                   state <= FETCH;
                 end
               end
        HALT:  state <= HALT;
      endcase
    end
  end
`else
  assign npc      = npc_raw & 32'hFFFF_FFFC;
  assign misalign = 1'b0;

  // Fetch sequencer; targets are word-aligned so HALT is never entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (imem_ack) begin
                 instr <= imem_rdata;
                 state <= HOLD;
               end
        HOLD:  if (instr_ready) begin
                 pc    <= npc;
                 state <= FETCH;
               end
        HALT:  state <= HALT;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table, corner sequences, random vs model
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [2:0]  npc_op = '0;
  logic        br_taken = 1'b0;
  logic [31:0] rs_data = '0;
  logic        misalign;

  int n_pass = 0;
  int n_total = 0;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc4(pc4),
    .npc_op(npc_op), .br_taken(br_taken), .rs_data(rs_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nseq;
    logic [31:0] ins;
    logic [2:0]  op;
    logic        br;
    logic [31:0] rs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Leaves the bench at a falling edge with the unit in its first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    npc_op = '0; br_taken = 1'b0; rs_data = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [2:0] op, input logic br, input logic [31:0] rs);
    instr_ready = 1'b1; npc_op = op; br_taken = br; rs_data = rs;
    @(negedge clk);
    instr_ready = 1'b0; npc_op = $urandom_range(0, 7); br_taken = $urandom_range(0, 1);
    rs_data = $urandom;
  endtask

  // Reference next-PC derived from the architectural rules with plain integer arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] ins,
                                          input logic [2:0] op, input logic br, input logic [31:0] rs);
    logic [31:0] r;
    int          off;
    logic [15:0] imm;
    logic [25:0] idx;
    imm = ins[15:0];
    idx = ins[25:0];
    off = int'($signed(imm));
    case (op)
      3'd1:    r = br ? p + 32'd4 + 32'(off * 4) : p + 32'd4;
      3'd2,
      3'd3:    r = (p & 32'hF000_0000) + 32'(idx) * 32'd4;
      3'd4:    r = rs;
      default: r = p + 32'd4;
    endcase
`ifndef IFU_ALIGN_CHECK_EN
    r = r - (r % 4);
`endif
    return r;
  endfunction

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_hold;
  logic [31:0] a0;
  int          retires;

  initial begin
    vecs[0] = '{4, 32'h0000_FFFC, 3'd1, 1'b1, 32'h0, 32'h0000_3004};
    vecs[1] = '{4, 32'h0000_FFFC, 3'd1, 1'b0, 32'h0, 32'h0000_3014};
    vecs[2] = '{0, 32'h0C00_0C10, 3'd3, 1'b0, 32'h0, 32'h0000_3040};
    vecs[3] = '{0, 32'h0800_0C10, 3'd2, 1'b1, 32'h0, 32'h0000_3040};
    vecs[4] = '{0, 32'h0000_0000, 3'd4, 1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{0, 32'h0000_0010, 3'd1, 1'b1, 32'h0, 32'h0000_3044};
    vecs[6] = '{0, 32'h0000_0010, 3'd0, 1'b1, 32'h9999_0000, 32'h0000_3004};
    vecs[7] = '{0, 32'h0000_0010, 3'd5, 1'b1, 32'h9999_0000, 32'h0000_3004};
    vecs[8] = '{0, 32'h0000_0010, 3'd7, 1'b1, 32'h9999_0000, 32'h0000_3004};
    vecs[9] = '{1, 32'hFFFF_FFFF, 3'd1, 1'b1, 32'h0, 32'h0000_3004};

    // Values while reset is held.
    @(negedge clk);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc4", pc4, 32'h3004);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);

    // Back-to-back with ack and ready tied high.
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; npc_op = 3'd0;
    @(negedge clk);
    chk("b2b_req0", 32'(imem_req), 32'h1);
    chk("b2b_addr0", imem_addr, 32'h3000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(instr_valid), 32'h1);
      chk("b2b_noreq", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("b2b_req", 32'(imem_req), 32'h1);
      chk("b2b_addr", imem_addr, 32'h3004 + 32'(i * 4));
      chk("b2b_notvalid", 32'(instr_valid), 32'h0);
    end

    // Next-PC vectors.
    foreach (vecs[k]) begin
      do_reset();
      for (int s = 0; s < vecs[k].nseq; s++) begin
        fetch(32'h0);
        retire(3'd0, 1'b0, 32'h0);
      end
      fetch(vecs[k].ins);
      chk($sformatf("vec%0d_pc4", k), pc4, 32'h3004 + 32'(vecs[k].nseq * 4));
      chk($sformatf("vec%0d_instr", k), instr, vecs[k].ins);
      retire(vecs[k].op, vecs[k].br, vecs[k].rs);
      chk($sformatf("vec%0d_addr", k), imem_addr, vecs[k].exp);
      chk($sformatf("vec%0d_req", k), 32'(imem_req), 32'h1);
    end

    // Backpressure: late ack, then stalled ready.
    do_reset();
    retires = 0;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      @(negedge clk);
      chk("bp_addr", imem_addr, 32'h3000);
      chk("bp_req", 32'(imem_req), 32'h1);
    end
    fetch(32'hA5A5_1234);
    for (int i = 0; i < 4; i++) begin
      instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      chk("bp_instr", instr, 32'hA5A5_1234);
      chk("bp_pc", pc, 32'h3000);
      chk("bp_valid", 32'(instr_valid), 32'h1);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1; npc_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      if (instr_valid && instr_ready) retires++;
      @(negedge clk);
    end
    instr_ready = 1'b0;
    chk("bp_retires", 32'(retires), 32'd1);
    chk("bp_next_addr", imem_addr, 32'h3004);

    // Wrap-around of sequential PC.
    do_reset();
    fetch(32'h0);
    retire(3'd4, 1'b0, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    fetch(32'h0);
    retire(3'd0, 1'b0, 32'h0);
    chk("wrap_seq", imem_addr, 32'h0);

    // Misaligned jr target.
    do_reset();
    fetch(32'h0);
    retire(3'd4, 1'b0, 32'h0000_3002);
`ifdef IFU_ALIGN_CHECK_EN
    chk("jr_misalign", 32'(misalign), 32'h1);
    chk("jr_pc", pc, 32'h3000);
    imem_ack = 1'b1; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_req", 32'(imem_req), 32'h0);
    chk("halt_valid", 32'(instr_valid), 32'h0);
    chk("halt_misalign", 32'(misalign), 32'h1);
    imem_ack = 1'b0; instr_ready = 1'b0;
`else
    chk("jr_addr", imem_addr, 32'h3000);
    chk("jr_misalign", 32'(misalign), 32'h0);
    chk("jr_req", 32'(imem_req), 32'h1);
`endif

    // Reset asserted while an instruction is held.
    do_reset();
    fetch(32'h0);
    retire(3'd0, 1'b0, 32'h0);
    fetch(32'hDEAD_BEEF);
    chk("mid_valid_before", 32'(instr_valid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_valid", 32'(instr_valid), 32'h0);
    chk("mid_instr", instr, 32'h0);
    chk("mid_pc", pc, 32'h3000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_restart", imem_addr, 32'h3000);
    chk("mid_restart_req", 32'(imem_req), 32'h1);

    // Randomised run against the transaction-level model.
    do_reset();
    m_pc = 32'h3000; m_instr = 32'h0; m_hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      chk("rnd_req", 32'(imem_req), 32'(!m_hold));
      chk("rnd_valid", 32'(instr_valid), 32'(m_hold));
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_pc4", pc4, m_pc + 32'd4);
      chk("rnd_instr", instr, m_instr);
      chk("rnd_misalign", 32'(misalign), 32'h0);
      imem_ack    = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      imem_rdata  = $urandom;
      npc_op      = $urandom_range(0, 7);
      br_taken    = $urandom_range(0, 1);
      a0          = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
      a0 = a0 & 32'hFFFF_FFFC;
`endif
      rs_data = a0;
      if (!m_hold && imem_ack) begin
        m_instr = imem_rdata;
        m_hold  = 1'b1;
      end else if (m_hold && instr_ready) begin
        m_pc   = ref_npc(m_pc, m_instr, npc_op, br_taken, rs_data);
        m_hold = 1'b0;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
